hs_fifo_responder: RTL and testbench

Elastic buffer for the dataflow fabric's req/ack protocol.
- Upstream side is an initiator: it pulls words from a producer or operator output by raising req_l and waiting for ack_l.
- Downstream side is a responder: it answers the joined req_r of one or more operator inputs with a one-cycle ack_r pulse and registered dout.
- Inserted between operators in generated graphs to decouple throughput, replacing chains of single-word reg operators.

---
 rtl/hs_fifo_responder_if.sv | 34 +++
 rtl/hs_fifo_responder.sv | 126 ++++++++++++
 tb/tb_hs_fifo_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hs_fifo_responder_if.sv
// Req/ack handshake bundle between the elastic buffer and its neighbours.
// Upstream half (req_l/ack_l/din): the buffer initiates.
// Downstream half (req_r/ack_r/dout): the buffer responds.
interface hs_fifo_responder_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUTPUT_SIZE = 1
);
  logic                   req_l;
  logic                   ack_l;
  logic [DATA_WIDTH-1:0]  din;
  logic [OUTPUT_SIZE-1:0] req_r;
  logic                   ack_r;
  logic [DATA_WIDTH-1:0]  dout;

  // Buffer side.
  modport slave (
    output req_l,
    input  ack_l,
    input  din,
    input  req_r,
    output ack_r,
    output dout
  );

  // Producer / consumer side.
  modport master (
    input  req_l,
    output ack_l,
    output din,
    output req_r,
    input  ack_r,
    input  dout
  );
endinterface

// File: rtl/hs_fifo_responder.sv
// Elastic req/ack buffer for the dataflow fabric.
//
// The upstream side pulls one word per request. An asserted req_l always
// owns one free slot, so an ack can never overflow the memory.
//
// The downstream side answers the AND of all req_r bits with a single-cycle
// ack_r pulse and a registered dout.
//
// Optional macro HS_FIFO_RESPONDER_BYPASS_EN: when the buffer is empty and
// both sides are ready on the same edge, din is forwarded straight to dout.
// This gives 1-cycle latency instead of 2.
module hs_fifo_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int OUTPUT_SIZE = 1,
  localparam int PW         = $clog2(DEPTH),
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  hs_fifo_responder_if.slave     bus,
  output logic [LW-1:0]          o_level,
  output logic [31:0]            o_count
);

  localparam logic [LW:0]   DEPTH_U = (LW+1)'(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr;
  logic [PW-1:0]         r_rd;
  logic [LW-1:0]         r_level;
  logic                  r_req_l;
  logic                  r_ack_r;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [31:0]           r_count;

  logic        w_req_all;
  logic        w_ack_fire;
  logic        w_byp;
  logic        w_wr_fire;
  logic        w_rd_fire;
  logic        w_deliver;
  logic [LW:0] w_used;
  logic        w_has_space;

  assign w_req_all  = &bus.req_r;

  // An ack only counts against an outstanding request; a stray ack is ignored.
  assign w_ack_fire = bus.ack_l & r_req_l;

`ifdef HS_FIFO_RESPONDER_BYPASS_EN
  assign w_byp = (r_level == '0) & w_ack_fire & w_req_all & ~r_ack_r;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed word never touches memory.
  assign w_wr_fire = w_ack_fire & ~w_byp;

  // ack_r must drop for at least one cycle between pulses.
  assign w_rd_fire = w_req_all & ~r_ack_r & (r_level != '0);
  assign w_deliver = w_rd_fire | w_byp;

  // Slots already committed: stored words plus the one reserved by a live req_l.
  assign w_used      = {1'b0, r_level} + {{LW{1'b0}}, r_req_l};
  assign w_has_space = (w_used < DEPTH_U);

  // Storage array; contents are don't-care after reset because pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire && !i_rst) r_mem[r_wr] <= bus.din;
  end

  // Upstream initiator: raise req_l when a slot can be reserved, drop on ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_l <= 1'b0;
      r_wr    <= '0;
    end else if (w_ack_fire) begin
      r_req_l <= 1'b0;
      if (w_wr_fire) r_wr <= r_wr + PW'(1);
    end else if (!r_req_l && w_has_space) begin
      r_req_l <= 1'b1;
    end
  end

  // Downstream responder: one-cycle ack_r pulse with a registered word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack_r <= 1'b0;
      r_dout  <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_ack_r <= w_deliver;
      if (w_byp) begin
        r_dout <= bus.din;
      end else if (w_rd_fire) begin
        r_dout <= r_mem[r_rd];
        r_rd   <= r_rd + PW'(1);
      end
      if (w_deliver) r_count <= r_count + 32'd1;
    end
  end

  // Occupancy tracks stored words only; a write and read on one edge cancel.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_level <= '0;
    else       r_level <= r_level + LW'(w_wr_fire) - LW'(w_rd_fire);
  end

  assign bus.req_l = r_req_l;
  assign bus.ack_r = r_ack_r;
  assign bus.dout  = r_dout;
  assign o_level   = r_level;
  assign o_count   = r_count;

  // The reservation rule must keep occupancy within the memory.
  a_level_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    r_level <= DEPTH_L);

  // Consecutive ack_r pulses would break the downstream protocol.
  a_ack_spacing: assert property (@(posedge i_clk) disable iff (i_rst)
    r_ack_r |=> !r_ack_r);

endmodule

// File: tb/tb_hs_fifo_responder.sv
// Directed bench for hs_fifo_responder (DEPTH=4, OUTPUT_SIZE=2).
// Covers reset, streaming, full, fan-in join, mid-run reset and the bypass edge.
module tb_hs_fifo_responder;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int OS = 2;

`ifdef HS_FIFO_RESPONDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  level;
  logic [31:0] count;

  int n_total = 0;
  int n_bad = 0;

  logic [DW-1:0] q[$];
  int pulses = 0;
  int b2b = 0;
  bit prev_ack = 1'b0;

  hs_fifo_responder_if #(.DATA_WIDTH(DW), .OUTPUT_SIZE(OS)) bus();

  hs_fifo_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OUTPUT_SIZE(OS)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_level(level),
    .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Sink monitor: log every delivered word and any back-to-back ack_r.
  always @(negedge clk) begin
    if (bus.ack_r) begin
      q.push_back(bus.dout);
      pulses++;
      if (prev_ack) b2b++;
    end
    prev_ack = bus.ack_r;
  end

  // Producer: wait for req_l (bounded), then present one word with ack_l for a cycle.
  task automatic produce(input logic [DW-1:0] v);
    int n = 0;
    while (!bus.req_l && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_l_timeout", 64'(n < 50), 64'd1);
    bus.ack_l = 1'b1;
    bus.din   = v;
    @(negedge clk);
    bus.ack_l = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p0;
    bit seen;

    bus.ack_l = 1'b0;
    bus.din   = '0;
    bus.req_r = 2'b11;

    // 1: reset then idle
    idle(3);
    chk("rst_req_l", 64'(bus.req_l), 64'd0);
    chk("rst_ack_r", 64'(bus.ack_r), 64'd0);
    chk("rst_dout",  64'(bus.dout),  64'd0);
    chk("rst_level", 64'(level),     64'd0);
    chk("rst_count", 64'(count),     64'd0);
    rst = 1'b0;
    idle(1);
    chk("req_l_rise", 64'(bus.req_l), 64'd1);
    idle(8);
    chk("idle_pulses", 64'(pulses), 64'd0);
    chk("idle_level",  64'(level),  64'd0);
    chk("idle_dout",   64'(bus.dout), 64'd0);

    // 2: streaming 0..99
    q.delete();
    for (int i = 0; i < 100; i++) produce(DW'(i));
    idle(10);
    chk("stream_size", 64'(q.size()), 64'd100);
    for (int i = 0; i < 100 && i < q.size(); i++)
      chk($sformatf("stream_%0d", i), 64'(q[i]), 64'(i));
    chk("stream_count", 64'(count), 64'd100);
    chk("stream_b2b",   64'(b2b),   64'd0);
    chk("stream_level", 64'(level), 64'd0);

    // 6: empty buffer, one word of 42
    chk("byp_pre_req_l", 64'(bus.req_l), 64'd1);
    bus.ack_l = 1'b1;
    bus.din   = 32'd42;
    idle(1);
    bus.ack_l = 1'b0;
    chk("byp_ack_r_t1", 64'(bus.ack_r), BYP ? 64'd1 : 64'd0);
    chk("byp_level_t1", 64'(level),     BYP ? 64'd0 : 64'd1);
    if (BYP) chk("byp_dout_t1", 64'(bus.dout), 64'd42);
    idle(1);
    chk("byp_ack_r_t2", 64'(bus.ack_r), BYP ? 64'd0 : 64'd1);
    chk("byp_dout_t2",  64'(bus.dout),  64'd42);
    chk("byp_level_t2", 64'(level),     64'd0);
    chk("byp_count",    64'(count),     64'd101);
    idle(4);

    // 3: fill to full with no downstream request
    bus.req_r = 2'b00;
    for (int i = 4; i < 8; i++) produce(DW'(i));
    chk("full_level", 64'(level), 64'd4);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (bus.req_l) seen = 1'b1;
    end
    chk("full_req_l_low", 64'(seen), 64'd0);
    bus.req_r = 2'b11;
    idle(1);
    chk("full_ack_r",  64'(bus.ack_r), 64'd1);
    chk("full_dout",   64'(bus.dout),  64'd4);
    chk("full_req_l0", 64'(bus.req_l), 64'd0);
    chk("full_level3", 64'(level),     64'd3);
    bus.req_r = 2'b01;
    idle(1);
    chk("full_req_l1", 64'(bus.req_l), 64'd1);

    // 4: partial join holds off delivery
    p0 = pulses;
    idle(10);
    chk("join_no_ack", 64'(pulses - p0), 64'd0);
    chk("join_level",  64'(level),       64'd3);
    bus.req_r = 2'b11;
    idle(1);
    chk("join_ack_r", 64'(bus.ack_r), 64'd1);
    chk("join_dout",  64'(bus.dout),  64'd5);
    chk("join_level2", 64'(level),    64'd2);
    idle(8);
    chk("join_drained", 64'(level), 64'd0);

    // 5: reset mid-operation with level=3 and req_l=1
    bus.req_r = 2'b00;
    for (int i = 4; i < 7; i++) produce(DW'(i));
    idle(1);
    chk("mid_pre_level", 64'(level),     64'd3);
    chk("mid_pre_req_l", 64'(bus.req_l), 64'd1);
    rst       = 1'b1;
    bus.ack_l = 1'b1;
    bus.din   = 32'd99;
    idle(1);
    rst       = 1'b0;
    bus.ack_l = 1'b0;
    chk("mid_level", 64'(level),     64'd0);
    chk("mid_count", 64'(count),     64'd0);
    chk("mid_ack_r", 64'(bus.ack_r), 64'd0);
    chk("mid_req_l", 64'(bus.req_l), 64'd0);
    q.delete();
    bus.req_r = 2'b11;
    produce(32'd7);
    produce(32'd8);
    idle(6);
    chk("mid_q_size", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      chk("mid_q0", 64'(q[0]), 64'd7);
      chk("mid_q1", 64'(q[1]), 64'd8);
    end
    chk("mid_count2", 64'(count), 64'd2);
    chk("total_b2b",  64'(b2b),   64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
